// File: rtl/response_router.sv
// response_router: steers in-order resource responses back to the issuing arbiter port
// Ports:
//   clk, rst (async, active-low)
//   grant/active/issue  -> tag push from the arbiter side; full/outstanding report occupancy
//   resp_valid/resp_data/resp_ready -> response stream from the shared resource
//   port_valid/port_data/port_ready -> per-port delivery, data broadcast to all ports
//   err -> sticky {orphan response, bad grant, overflow}
module response_router #(
    parameter int NUM_PORTS  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int IDX_W     = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1,
    localparam int CNT_W     = $clog2(DEPTH) + 1,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:NUM_PORTS-1]  grant,
    input  logic                  active,
    input  logic                  issue,
    output logic                  full,
    output logic [CNT_W-1:0]      outstanding,
    input  logic                  resp_valid,
    input  logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_ready,
    output logic [0:NUM_PORTS-1]  port_valid,
    output logic [DATA_WIDTH-1:0] port_data,
    input  logic [0:NUM_PORTS-1]  port_ready,
    output logic [2:0]            err
);
    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp, rp;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] tag, head;
    logic [0:NUM_PORTS-1] hsel;
    logic onehot, nonempty, push, pop;

    assign onehot      = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
    assign nonempty    = count != '0;
    assign full        = count == CNT_W'(DEPTH);
    assign outstanding = count;
    assign head        = mem[rp];
    assign port_data   = resp_data;
    assign push        = issue & active & onehot & ~full;
    assign pop         = resp_valid & resp_ready;
    assign resp_ready  = |(hsel & port_ready);

    always_comb begin
        tag        = '0;
        hsel       = '0;
        port_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) tag = tag | IDX_W'(i);
            hsel[i]       = nonempty & (head == IDX_W'(i));
            port_valid[i] = resp_valid & hsel[i];
        end
    end

    // Tag storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk)
        if (push) mem[wp] <= tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            err   <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count  <= count + CNT_W'(push) - CNT_W'(pop);
            err[0] <= err[0] | (issue & full);
            err[1] <= err[1] | (issue & (~active | ~onehot));
            err[2] <= err[2] | (resp_valid & ~nonempty);
        end
    end
endmodule

// File: doc/response_router.md
Name: response_router

Overview:
- Return-path companion to the round-robin bus arbiter. The arbiter steers requests to the shared resource; this block steers the resource's in-order responses back to the port that issued each transaction.
- Each accepted issue pushes the encoded grant index into a tag FIFO.
- Each response is delivered to the port named by the FIFO head, with per-port valid/ready handshake and backpressure to the resource.

Parameters:
- NUM_PORTS, 6, number of requesting ports; matches the arbiter's NUM_PORTS.
- DATA_WIDTH, 32, response data width.
- DEPTH, 8, maximum outstanding transactions; power of 2, >= 2.
- IDX_W, derived local value = ceil(log2(NUM_PORTS)), minimum 1; tag width.
- CNT_W, derived local value = log2(DEPTH)+1; width of the occupancy count.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- grant  input  [0:NUM_PORTS-1]  registered one-hot grant from arbiter; grant[0] = port 0.
- active  input  1  arbiter active flag, same cycle as grant.
- issue  input  1  resource accepted the granted port's transaction this cycle.
- full  output  1  tag FIFO holds DEPTH entries; upstream must not issue.
- outstanding  output  CNT_W  current FIFO occupancy, 0..DEPTH.
- resp_valid  input  1  resource presents a response.
- resp_data  input  DATA_WIDTH  response payload.
- resp_ready  output  1  response consumed this cycle when resp_valid is high.
- port_valid  output  [0:NUM_PORTS-1]  at most one bit high; response for that port.
- port_data  output  DATA_WIDTH  broadcast copy of resp_data to all ports.
- port_ready  input  [0:NUM_PORTS-1]  per-port consumer ready.
- err  output  3  sticky flags. Bit0 = overflow (issue while full). Bit1 = bad grant (issue with active low, or grant not exactly one-hot). Bit2 = orphan response (resp_valid while FIFO empty).

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO read and write pointers, count and err all clear to 0.
  - Resulting outputs: full=0, outstanding=0, resp_ready=0, port_valid=0.
  - port_data follows resp_data; it is not reset.
  - Reset mid-operation discards all tags. Responses for those tags later raise err[2].
- Push:
  - push = issue & active & onehot(grant) & ~full.
  - Tag = index of the single set grant bit, 0..NUM_PORTS-1.
  - The tag is written at the write pointer, which then increments and wraps modulo DEPTH.
- Push errors:
  - issue & full: no write, set err[0].
  - issue & (~active | grant zero | grant multi-hot): no write, set err[1].
  - Both conditions in one cycle: set both bits, no write.
- Head: head = entry at the read pointer, valid when count != 0.
  - A tag pushed at edge N is visible as head from cycle N+1.
  - The response path never bypasses the FIFO.
- Response steering (combinational, zero latency):
  - port_valid[i] = resp_valid & (count != 0) & (head == i).
  - resp_ready = (count != 0) & port_ready[head].
  - resp_ready does not depend on resp_valid.
  - Bits of port_ready other than the head's are ignored.
- Pop: pop = resp_valid & resp_ready. The read pointer increments and wraps modulo DEPTH.
- Empty FIFO: resp_valid while count == 0 keeps resp_ready=0 and port_valid all zero, and sets err[2] each such cycle.
- Count:
  - next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged and pointers both advance.
  - full = (count == DEPTH).
  - At full, a same-cycle pop does not permit a push: full is registered-count based, so issue is rejected and err[0] is set.
- Stability: while resp_valid is high and the head port is not ready, the head and port_valid hold. resp_data must be held by the resource, as in the valid/ready convention.
- err bits clear only on reset.
- Ordering: responses are delivered strictly in issue order. Per-port reordering is out of scope.

Test Plan:
- Single transaction: grant=port 2, active=1, issue=1 for one cycle; next cycle resp_valid=1, data=0xA5A5A5A5, port_ready all ones -> port_valid = bit 2 only, port_data=0xA5A5A5A5, resp_ready=1, outstanding 1->0.
- Interleave: issue ports 0,5,3,0 on consecutive cycles, then four responses D0..D3 -> delivered to ports 0,5,3,0 in order; outstanding peaks at 4 and returns to 0.
- Backpressure: head=port 1, resp_valid=1, port_ready[1]=0 for 3 cycles, other port_ready bits high -> resp_ready=0 and port_valid[1]=1 held; pop occurs in the cycle port_ready[1] rises.
- Full/wrap: issue DEPTH=8 times -> full=1, outstanding=8. 9th issue -> dropped, err[0]=1. Drain 8, then issue 8 more -> pointers wrap and tags are delivered correctly.
- Simultaneous push/pop at count=3 -> count stays 3; the new tag is delivered after the older three.
- Errors and reset: issue with grant=0b110000 -> err[1]=1, no push. resp_valid with empty FIFO -> err[2]=1, resp_ready=0. Drive rst low mid-stream with count=4 -> outputs clear immediately without a clock edge, err=0, outstanding=0.
